// File: rtl/wb_grf.sv
// MEM/WB pipeline register, writeback mux and 32x32 general register file
// with internal write-to-read bypass, sticky select-error flag and retire counter.
module wb_grf #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic        in_regwrite,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [1:0]  in_a3_sel,
    input  logic [1:0]  in_wd_sel,
    input  logic [31:0] in_alu,
    input  logic [31:0] in_dm,
    input  logic [31:0] in_pc,
    input  logic [4:0]  rd1_addr,
    input  logic [4:0]  rd2_addr,
    output logic [31:0] rd1_data,
    output logic [31:0] rd2_data,
    output logic        wb_we,
    output logic [4:0]  wb_a3,
    output logic [31:0] wb_wd,
    output logic [31:0] wb_pc,
    output logic        sel_err,
    output logic [31:0] retired
);

    logic        valid_q;
    logic        regwrite_q;
    logic [4:0]  rt_q;
    logic [4:0]  rd_q;
    logic [1:0]  a3_sel_q;
    logic [1:0]  wd_sel_q;
    logic [31:0] alu_q;
    logic [31:0] dm_q;
    logic [31:0] pc_q;

    logic [31:0] grf [0:31];
    logic        sel_err_q;
    logic [31:0] retired_q;

    logic [4:0]  a3_dec;
    logic [31:0] wd_dec;
    logic        we_int;
    logic        bad_sel;

    // Flush only needs to kill valid; the payload fields are ignored once valid is low.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            rt_q       <= 5'd0;
            rd_q       <= 5'd0;
            a3_sel_q   <= 2'd0;
            wd_sel_q   <= 2'd0;
            alu_q      <= 32'd0;
            dm_q       <= 32'd0;
            pc_q       <= RESET_PC;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (!stall) begin
            valid_q    <= in_valid;
            regwrite_q <= in_regwrite;
            rt_q       <= in_rt;
            rd_q       <= in_rd;
            a3_sel_q   <= in_a3_sel;
            wd_sel_q   <= in_wd_sel;
            alu_q      <= in_alu;
            dm_q       <= in_dm;
            pc_q       <= in_pc;
        end
    end

    always_comb begin
        a3_dec = 5'd0;
        wd_dec = 32'd0;
        case (a3_sel_q)
            2'd0:    a3_dec = rt_q;
            2'd1:    a3_dec = rd_q;
            2'd2:    a3_dec = 5'd31;
            default: a3_dec = 5'd0;
        endcase
        case (wd_sel_q)
            2'd0:    wd_dec = alu_q;
            2'd1:    wd_dec = dm_q;
            2'd2:    wd_dec = pc_q + 32'd8;
            default: wd_dec = 32'd0;
        endcase
    end

    assign bad_sel = (a3_sel_q == 2'd3) || (wd_sel_q == 2'd3);

    // A stalled instruction must not write, so it commits exactly once after release.
    assign we_int = reset_n && valid_q && regwrite_q && (a3_dec != 5'd0)
                    && !bad_sel && !stall;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                grf[i] <= 32'd0;
            end
        end else if (we_int) begin
            grf[a3_dec] <= wd_dec;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sel_err_q <= 1'b0;
            retired_q <= 32'd0;
        end else begin
            if (valid_q && regwrite_q && !stall && bad_sel) begin
                sel_err_q <= 1'b1;
            end
            if (valid_q && !stall) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    // Reads forward the committing value so a consumer in the same cycle sees it.
    always_comb begin
        rd1_data = 32'd0;
        rd2_data = 32'd0;
        if (reset_n) begin
            if (rd1_addr == 5'd0) begin
                rd1_data = 32'd0;
            end else if (we_int && (rd1_addr == a3_dec)) begin
                rd1_data = wd_dec;
            end else begin
                rd1_data = grf[rd1_addr];
            end
            if (rd2_addr == 5'd0) begin
                rd2_data = 32'd0;
            end else if (we_int && (rd2_addr == a3_dec)) begin
                rd2_data = wd_dec;
            end else begin
                rd2_data = grf[rd2_addr];
            end
        end
    end

    assign wb_we   = we_int;
    assign wb_a3   = reset_n ? a3_dec : 5'd0;
    assign wb_wd   = reset_n ? wd_dec : 32'd0;
    assign wb_pc   = reset_n ? pc_q : RESET_PC;
    assign sel_err = sel_err_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_wb_grf.sv
// Directed bench for wb_grf: a vector table of single instructions plus
// hand-written stall, flush, select-error and reset sequences.
module tb_wb_grf;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic        in_regwrite;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [1:0]  in_a3_sel;
    logic [1:0]  in_wd_sel;
    logic [31:0] in_alu;
    logic [31:0] in_dm;
    logic [31:0] in_pc;
    logic [4:0]  rd1_addr;
    logic [4:0]  rd2_addr;
    logic [31:0] rd1_data;
    logic [31:0] rd2_data;
    logic        wb_we;
    logic [4:0]  wb_a3;
    logic [31:0] wb_wd;
    logic [31:0] wb_pc;
    logic        sel_err;
    logic [31:0] retired;

    int checks = 0;
    int fails  = 0;
    logic [31:0] exp_retired;

    typedef struct {
        logic        regwrite;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [1:0]  a3_sel;
        logic [1:0]  wd_sel;
        logic [31:0] alu;
        logic [31:0] dm;
        logic [31:0] pc;
        logic        exp_we;
        logic [4:0]  exp_a3;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [7];

    wb_grf #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_regwrite(in_regwrite),
        .in_rt(in_rt), .in_rd(in_rd), .in_a3_sel(in_a3_sel), .in_wd_sel(in_wd_sel),
        .in_alu(in_alu), .in_dm(in_dm), .in_pc(in_pc),
        .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
        .rd1_data(rd1_data), .rd2_data(rd2_data),
        .wb_we(wb_we), .wb_a3(wb_a3), .wb_wd(wb_wd), .wb_pc(wb_pc),
        .sel_err(sel_err), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic driveInstr(input logic rw, input logic [4:0] rt, input logic [4:0] rd,
                              input logic [1:0] a3s, input logic [1:0] wds,
                              input logic [31:0] alu, input logic [31:0] dm, input logic [31:0] pc);
        in_valid    = 1'b1;
        in_regwrite = rw;
        in_rt       = rt;
        in_rd       = rd;
        in_a3_sel   = a3s;
        in_wd_sel   = wds;
        in_alu      = alu;
        in_dm       = dm;
        in_pc       = pc;
    endtask

    // Loads one vector into WB, checks the WB cycle, then the committed state.
    task automatic applyStimulus(input vec_t v);
        driveInstr(v.regwrite, v.rt, v.rd, v.a3_sel, v.wd_sel, v.alu, v.dm, v.pc);
        tick();
        in_valid = 1'b0;
        rd1_addr = v.exp_a3;
        rd2_addr = 5'd0;
        #1;
        checkOutput("vec_we", {31'd0, wb_we}, {31'd0, v.exp_we});
        checkOutput("vec_a3", {27'd0, wb_a3}, {27'd0, v.exp_a3});
        checkOutput("vec_wd", wb_wd, v.exp_wd);
        checkOutput("vec_pc", wb_pc, v.pc);
        checkOutput("vec_bypass", rd1_data, v.exp_rd);
        checkOutput("vec_rd2_zero", rd2_data, 32'd0);
        tick();
        exp_retired++;
        checkOutput("vec_retired", retired, exp_retired);
        checkOutput("vec_stored", rd1_data, v.exp_rd);
        checkOutput("vec_we_after", {31'd0, wb_we}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd0,  5'd0,  2'd2, 2'd2, 32'h0,         32'h0,         32'h0000_3010, 1'b1, 5'd31, 32'h0000_3018, 32'h0000_3018};
        vecs[1] = '{1'b1, 5'd8,  5'd3,  2'd0, 2'd1, 32'h1111_1111, 32'hDEAD_BEEF, 32'h0000_3014, 1'b1, 5'd8,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 5'd2,  5'd9,  2'd1, 2'd0, 32'h0000_00A5, 32'h0,         32'h0000_3018, 1'b1, 5'd9,  32'h0000_00A5, 32'h0000_00A5};
        vecs[3] = '{1'b1, 5'd4,  5'd0,  2'd1, 2'd0, 32'h0000_1234, 32'h0,         32'h0000_301C, 1'b0, 5'd0,  32'h0000_1234, 32'h0};
        vecs[4] = '{1'b0, 5'd10, 5'd11, 2'd0, 2'd0, 32'h0000_0077, 32'h0,         32'h0000_3020, 1'b0, 5'd10, 32'h0000_0077, 32'h0};
        vecs[5] = '{1'b1, 5'd1,  5'd12, 2'd1, 2'd2, 32'h0,         32'h0,         32'hFFFF_FFFC, 1'b1, 5'd12, 32'h0000_0004, 32'h0000_0004};
        vecs[6] = '{1'b1, 5'd20, 5'd5,  2'd0, 2'd1, 32'h0,         32'hCAFE_0001, 32'h0000_3024, 1'b1, 5'd20, 32'hCAFE_0001, 32'hCAFE_0001};

        reset_n  = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        rd1_addr = 5'd31;
        rd2_addr = 5'd5;
        driveInstr(1'b1, 5'd7, 5'd7, 2'd1, 2'd0, 32'h5555_5555, 32'h0, 32'h0000_4000);
        #1;
        checkOutput("rst_early_we", {31'd0, wb_we}, 32'd0);
        checkOutput("rst_early_pc", wb_pc, 32'h0000_3000);
        tick();
        tick();
        checkOutput("rst_we", {31'd0, wb_we}, 32'd0);
        checkOutput("rst_a3", {27'd0, wb_a3}, 32'd0);
        checkOutput("rst_wd", wb_wd, 32'd0);
        checkOutput("rst_pc", wb_pc, 32'h0000_3000);
        checkOutput("rst_rd1", rd1_data, 32'd0);
        checkOutput("rst_rd2", rd2_data, 32'd0);
        checkOutput("rst_sel_err", {31'd0, sel_err}, 32'd0);
        checkOutput("rst_retired", retired, 32'd0);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        #1;
        checkOutput("post_rst_pc", wb_pc, 32'h0000_3000);
        checkOutput("post_rst_rd1", rd1_data, 32'd0);
        exp_retired = 32'd0;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
        end

        // Stall an add to $9 for three edges; GRF[9] keeps its old value.
        driveInstr(1'b1, 5'd0, 5'd9, 2'd1, 2'd0, 32'h0000_0005, 32'h0, 32'h0000_3100);
        tick();
        in_valid = 1'b0;
        stall    = 1'b1;
        rd1_addr = 5'd9;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("stall_we", {31'd0, wb_we}, 32'd0);
            checkOutput("stall_grf9", rd1_data, 32'h0000_00A5);
            tick();
        end
        checkOutput("stall_retired", retired, exp_retired);
        stall = 1'b0;
        #1;
        checkOutput("release_we", {31'd0, wb_we}, 32'd1);
        checkOutput("release_bypass", rd1_data, 32'h0000_0005);
        tick();
        exp_retired++;
        checkOutput("release_retired", retired, exp_retired);
        checkOutput("release_grf9", rd1_data, 32'h0000_0005);
        checkOutput("release_we_after", {31'd0, wb_we}, 32'd0);

        // Flush and stall on the same edge: the WB instruction is killed uncounted.
        driveInstr(1'b1, 5'd0, 5'd14, 2'd1, 2'd0, 32'h0000_0077, 32'h0, 32'h0000_3200);
        tick();
        stall    = 1'b1;
        flush    = 1'b1;
        rd1_addr = 5'd14;
        tick();
        stall    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("flush_we", {31'd0, wb_we}, 32'd0);
        checkOutput("flush_retired", retired, exp_retired);
        tick();
        checkOutput("flush_grf14", rd1_data, 32'd0);
        checkOutput("flush_retired2", retired, exp_retired);

        // Reserved a3 select: no write, sticky error.
        driveInstr(1'b1, 5'd15, 5'd15, 2'd3, 2'd0, 32'h0000_0099, 32'h0, 32'h0000_3300);
        tick();
        in_valid = 1'b0;
        #1;
        checkOutput("selerr_we", {31'd0, wb_we}, 32'd0);
        checkOutput("selerr_before", {31'd0, sel_err}, 32'd0);
        tick();
        exp_retired++;
        checkOutput("selerr_set", {31'd0, sel_err}, 32'd1);
        checkOutput("selerr_retired", retired, exp_retired);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("selerr_sticky", {31'd0, sel_err}, 32'd1);
        end

        // Reset with a writing instruction sitting in WB: it is dropped.
        driveInstr(1'b1, 5'd16, 5'd16, 2'd0, 2'd0, 32'h0000_0099, 32'h0, 32'h0000_3400);
        tick();
        in_valid = 1'b0;
        reset_n  = 1'b0;
        tick();
        reset_n  = 1'b1;
        rd1_addr = 5'd31;
        rd2_addr = 5'd16;
        #1;
        checkOutput("rst2_sel_err", {31'd0, sel_err}, 32'd0);
        checkOutput("rst2_retired", retired, 32'd0);
        checkOutput("rst2_grf31", rd1_data, 32'd0);
        checkOutput("rst2_grf16", rd2_data, 32'd0);
        checkOutput("rst2_pc", wb_pc, 32'h0000_3000);
        tick();
        checkOutput("rst2_retired_hold", retired, 32'd0);
        checkOutput("rst2_grf16_hold", rd2_data, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
